// File: rtl/perf_mon_pkg.sv
// perf_mon_pkg: shared constants and helpers for the performance monitor.
//   - Counter index map (cycle, instruction, first generic event channel).
//   - Default event-channel mapping for the cpu hookup.
//   - Saturating-increment helpers shared by the counter cells and the
//     optional shadow bank, so both agree on the post-update value.
package perf_mon_pkg;

    localparam int CYC_IDX     = 0;
    localparam int INST_IDX    = 1;
    localparam int EVT_BASE    = 2;

    localparam int CNT_W_DEF   = 32;
    localparam int NUM_EVT_DEF = 4;

    // Default meaning of the generic event channels.
    typedef enum logic [1:0] {
        DHIT = 2'd0,
        IHIT = 2'd1,
        DREQ = 2'd2,
        IREQ = 2'd3
    } evt_map_e;

    // Next value of a saturating counter; callers zero-extend into 64 bits
    // and truncate the result back to their own width.
    function automatic logic [63:0] sat_next(input logic [63:0] cnt,
                                             input logic [63:0] max_v,
                                             input logic        inc,
                                             input logic        hold,
                                             input logic        clr);
        logic [63:0] r;
        if (clr) begin
            r = 64'd0;
        end else if (hold || !inc || (cnt == max_v)) begin
            r = cnt;
        end else begin
            r = cnt + 64'd1;
        end
        return r;
    endfunction

    // True when an increment is attempted on a counter already at its maximum.
    function automatic logic sat_hit(input logic [63:0] cnt,
                                     input logic [63:0] max_v,
                                     input logic        inc,
                                     input logic        hold,
                                     input logic        clr);
        return !clr && !hold && inc && (cnt == max_v);
    endfunction

endpackage

// File: rtl/perf_monitor_if.sv
// perf_monitor_if: counter readback bus of the performance monitor.
//   rd_sel    counter index (0 cycle, 1 instruction, 2.. events)
//   rd_shadow 1 = read shadow copy (only meaningful with PERF_MON_SNAPSHOT_EN)
//   rd_data   registered counter value, one cycle after rd_sel is sampled
// master = reader (cpu/testbench side), slave = perf_monitor.
interface perf_monitor_if #(
    parameter int NUM_EVT = 4,
    parameter int CNT_W   = 32
);
    localparam int SEL_W = $clog2(NUM_EVT + 2);

    logic [SEL_W-1:0] rd_sel;
    logic             rd_shadow;
    logic [CNT_W-1:0] rd_data;

    modport master (output rd_sel, output rd_shadow, input rd_data);
    modport slave  (input rd_sel, input rd_shadow, output rd_data);
endinterface

// File: rtl/perf_sat_counter.sv
// perf_sat_counter: one W-bit saturating event counter with sticky overflow.
//   clk, rst_n  clock, asynchronous active-low reset
//   inc_i       count request this cycle
//   clr_i       synchronous clear of count and overflow flag (dominant)
//   hold_i      freeze the counter (monitor inactive)
//   count_o     registered count, holds at 2^W-1
//   ovf_o       sticky flag, set by the first increment attempted at 2^W-1
module perf_sat_counter
    import perf_mon_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    input  logic         hold_i,
    output logic [W-1:0] count_o,
    output logic         ovf_o
);
    localparam logic [63:0] MAX_V = 64'({W{1'b1}});

    logic [W-1:0] count_q, count_d;
    logic         ovf_q, ovf_d;

    // Next count and sticky overflow.
    always_comb begin
        count_d = W'(sat_next(64'(count_q), MAX_V, inc_i, hold_i, clr_i));
        if (clr_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q | sat_hit(64'(count_q), MAX_V, inc_i, hold_i, clr_i);
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {W{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign ovf_o   = ovf_q;
endmodule

// File: rtl/perf_monitor.sv
// perf_monitor: cycle / retired-instruction / event statistics beside the cpu.
// Optional feature macro: PERF_MON_SNAPSHOT_EN (shadow copy captured by snap_i).
//   clk, rst_n  clock, asynchronous active-low reset
//   en_i        counting enable
//   clr_i       synchronous clear of counters, ovf, timeout and frozen
//   retire_i    instruction-retire strobe
//   hlt_i       processor halt; freezes counting from the next cycle
//   evt_i       per-channel event strobes
//   snap_i      capture post-update counter values into the shadow bank
//   rd_bus      readback bus (rd_sel, rd_shadow in; registered rd_data out)
//   ovf_o       sticky per-counter saturation flags
//   frozen_o    counting stopped (halt or watchdog)
//   timeout_o   sticky watchdog flag (WDOG_LIMIT = 0 disables)
module perf_monitor
    import perf_mon_pkg::*;
#(
    parameter int NUM_EVT    = NUM_EVT_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int WDOG_LIMIT = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic               retire_i,
    input  logic               hlt_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               snap_i,
    perf_monitor_if.slave      rd_bus,
    output logic [NUM_EVT+1:0] ovf_o,
    output logic               frozen_o,
    output logic               timeout_o
);
    localparam int          NCNT    = NUM_EVT + 2;
    localparam logic [63:0] CNT_MAX = 64'({CNT_W{1'b1}});
    localparam logic [63:0] WDOG_V  = 64'(WDOG_LIMIT);

    logic             active_s;
    logic             hold_s;
    logic [NCNT-1:0]  inc_s;
    logic [CNT_W-1:0] cnt_s [NCNT];
    logic [NCNT-1:0]  ovf_s;
    logic [63:0]      cyc_post_s;
    logic             wdog_trip_s;

    logic             frozen_q, frozen_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;

    // Activity qualifier, strobe vector and watchdog comparison.
    always_comb begin
        active_s                  = en_i & ~frozen_q;
        hold_s                    = ~active_s;
        inc_s                     = {NCNT{1'b0}};
        inc_s[CYC_IDX]            = 1'b1;
        inc_s[INST_IDX]           = retire_i;
        inc_s[EVT_BASE +: NUM_EVT] = evt_i;
        // The watchdog compares the value the cycle counter will hold after
        // this edge, so the trip cycle itself is counted.
        cyc_post_s  = sat_next(64'(cnt_s[CYC_IDX]), CNT_MAX, 1'b1, hold_s, 1'b0);
        wdog_trip_s = (WDOG_V != 64'd0) && active_s && (cyc_post_s == WDOG_V);
    end

    for (genvar g = 0; g < NCNT; g++) begin : g_cnt
        perf_sat_counter #(.W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc_i   (inc_s[g]),
            .clr_i   (clr_i),
            .hold_i  (hold_s),
            .count_o (cnt_s[g]),
            .ovf_o   (ovf_s[g])
        );
    end

    // Freeze and watchdog flags; clr dominates halt and watchdog trips.
    always_comb begin
        if (clr_i) begin
            frozen_d  = 1'b0;
            timeout_d = 1'b0;
        end else begin
            frozen_d  = frozen_q | (active_s & (hlt_i | wdog_trip_s));
            timeout_d = timeout_q | wdog_trip_s;
        end
    end

`ifdef PERF_MON_SNAPSHOT_EN
    logic [CNT_W-1:0] shadow_q [NCNT];

    // Shadow bank takes the post-update values of the snap cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCNT; k++) begin
                shadow_q[k] <= {CNT_W{1'b0}};
            end
        end else if (snap_i) begin
            for (int k = 0; k < NCNT; k++) begin
                shadow_q[k] <= CNT_W'(sat_next(64'(cnt_s[k]), CNT_MAX, inc_s[k],
                                               hold_s, clr_i));
            end
        end else begin
            for (int k = 0; k < NCNT; k++) begin
                shadow_q[k] <= shadow_q[k];
            end
        end
    end

    // Readback mux: live or shadow, out-of-range indices read zero.
    always_comb begin
        rd_data_d = {CNT_W{1'b0}};
        if (int'(rd_bus.rd_sel) < NCNT) begin
            if (rd_bus.rd_shadow) begin
                rd_data_d = shadow_q[rd_bus.rd_sel];
            end else begin
                rd_data_d = cnt_s[rd_bus.rd_sel];
            end
        end else begin
            rd_data_d = {CNT_W{1'b0}};
        end
    end
`else
    logic unused_s;
    assign unused_s = snap_i ^ rd_bus.rd_shadow;

    // Readback mux: live counters only, out-of-range indices read zero.
    always_comb begin
        rd_data_d = {CNT_W{1'b0}};
        if (int'(rd_bus.rd_sel) < NCNT) begin
            rd_data_d = cnt_s[rd_bus.rd_sel];
        end else begin
            rd_data_d = {CNT_W{1'b0}};
        end
    end
`endif

    // Control flags and registered readback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frozen_q  <= 1'b0;
            timeout_q <= 1'b0;
            rd_data_q <= {CNT_W{1'b0}};
        end else begin
            frozen_q  <= frozen_d;
            timeout_q <= timeout_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_bus.rd_data = rd_data_q;
    assign ovf_o          = ovf_s;
    assign frozen_o       = frozen_q;
    assign timeout_o      = timeout_q;
endmodule

// File: tb/tb_perf_monitor.sv
// Bench for perf_monitor: two instances share stimulus, one 32-bit with a
// 100-cycle watchdog, one 4-bit with the watchdog disabled, both checked
// every cycle against an arithmetic model of the counting rules.
module tb_perf_monitor;
    import perf_mon_pkg::*;

`ifdef PERF_MON_SNAPSHOT_EN
    localparam bit SNAP_EN = 1'b1;
`else
    localparam bit SNAP_EN = 1'b0;
`endif
    localparam int NC = 6;

    logic       clk = 1'b0;
    logic       rst_n, en, clr, retire, hlt, snap, shadow;
    logic [3:0] evt;
    logic [2:0] sel;
    logic [5:0] ovf_w, ovf_s;
    logic       frz_w, frz_s, to_w, to_s;

    int vectors    = 0;
    int miscompares = 0;

    perf_monitor_if #(.NUM_EVT(4), .CNT_W(32)) bus_w ();
    perf_monitor_if #(.NUM_EVT(4), .CNT_W(4))  bus_s ();
    assign bus_w.rd_sel    = sel;
    assign bus_s.rd_sel    = sel;
    assign bus_w.rd_shadow = shadow;
    assign bus_s.rd_shadow = shadow;

    perf_monitor #(.NUM_EVT(4), .CNT_W(32), .WDOG_LIMIT(100)) u_w (
        .clk(clk), .rst_n(rst_n), .en_i(en), .clr_i(clr), .retire_i(retire),
        .hlt_i(hlt), .evt_i(evt), .snap_i(snap), .rd_bus(bus_w),
        .ovf_o(ovf_w), .frozen_o(frz_w), .timeout_o(to_w));

    perf_monitor #(.NUM_EVT(4), .CNT_W(4), .WDOG_LIMIT(0)) u_s (
        .clk(clk), .rst_n(rst_n), .en_i(en), .clr_i(clr), .retire_i(retire),
        .hlt_i(hlt), .evt_i(evt), .snap_i(snap), .rd_bus(bus_s),
        .ovf_o(ovf_s), .frozen_o(frz_s), .timeout_o(to_s));

    always #5 clk = ~clk;

    // Reference model state, index 0 = u_w, 1 = u_s.
    longint mcnt [2][NC];
    longint msh  [2][NC];
    bit     movf [2][NC];
    bit     mfrz [2];
    bit     mto  [2];
    longint mrd  [2];
    longint MAXV [2] = '{64'hFFFF_FFFF, 64'd15};
    longint WD   [2] = '{64'd100, 64'd0};

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < NC; k++) begin
                mcnt[d][k] = 0; msh[d][k] = 0; movf[d][k] = 1'b0;
            end
            mfrz[d] = 1'b0; mto[d] = 1'b0; mrd[d] = 0;
        end
    endtask

    // One clock edge of the counting rules.
    task automatic model_edge();
        logic [5:0] stb;
        stb = {evt, retire, 1'b1};
        for (int d = 0; d < 2; d++) begin
            if (int'(sel) < NC)
                mrd[d] = (SNAP_EN && shadow) ? msh[d][int'(sel)] : mcnt[d][int'(sel)];
            else
                mrd[d] = 0;
            if (clr) begin
                for (int k = 0; k < NC; k++) begin
                    mcnt[d][k] = 0; movf[d][k] = 1'b0;
                end
                mfrz[d] = 1'b0; mto[d] = 1'b0;
            end else if (en && !mfrz[d]) begin
                for (int k = 0; k < NC; k++) begin
                    if (stb[k]) begin
                        if (mcnt[d][k] == MAXV[d]) movf[d][k] = 1'b1;
                        else mcnt[d][k] = mcnt[d][k] + 1;
                    end
                end
                if (hlt) mfrz[d] = 1'b1;
                if (WD[d] != 0 && mcnt[d][0] == WD[d]) begin
                    mto[d] = 1'b1; mfrz[d] = 1'b1;
                end
            end
            if (SNAP_EN && snap)
                for (int k = 0; k < NC; k++) msh[d][k] = mcnt[d][k];
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] movf_vec(input int d);
        logic [5:0] v;
        for (int k = 0; k < NC; k++) v[k] = movf[d][k];
        return v;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_rd_w"},  64'(bus_w.rd_data), 64'(mrd[0]));
        chk({tag, "_rd_s"},  64'(bus_s.rd_data), 64'(mrd[1]));
        chk({tag, "_ovf_w"}, 64'(ovf_w), 64'(movf_vec(0)));
        chk({tag, "_ovf_s"}, 64'(ovf_s), 64'(movf_vec(1)));
        chk({tag, "_frz_w"}, 64'(frz_w), 64'(mfrz[0]));
        chk({tag, "_frz_s"}, 64'(frz_s), 64'(mfrz[1]));
        chk({tag, "_to_w"},  64'(to_w), 64'(mto[0]));
        chk({tag, "_to_s"},  64'(to_s), 64'(mto[1]));
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Read one counter on both instances and compare with fixed values.
    task automatic rd_expect(input logic [2:0] s, input longint ew, input longint es,
                             input string tag);
        sel = s;
        cyc({tag, "_rd"});
        chk({tag, "_const_w"}, 64'(bus_w.rd_data), 64'(ew));
        chk({tag, "_const_s"}, 64'(bus_s.rd_data), 64'(es));
    endtask

    task automatic do_clr();
        en = 1'b0; clr = 1'b1; retire = 1'b0; hlt = 1'b0; evt = 4'd0; snap = 1'b0;
        cyc("clr");
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; retire = 1'b0; hlt = 1'b0;
        snap = 1'b0; shadow = 1'b0; evt = 4'd0; sel = 3'd0;
        model_reset();
        #3;
        check_all("reset");
        #4 rst_n = 1'b1;

        // Basic counting: 10 active cycles, 4 retires, 3 evt[1].
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            retire = (i == 1 || i == 3 || i == 4 || i == 8);
            evt    = (i == 0 || i == 5 || i == 9) ? 4'b0010 : 4'b0000;
            sel    = 3'($urandom_range(7, 0));
            cyc("basic");
        end
        en = 1'b0; retire = 1'b0; evt = 4'd0;
        rd_expect(3'd0, 10, 10, "basic_cyc");
        rd_expect(3'd1, 4, 4, "basic_inst");
        rd_expect(3'd3, 3, 3, "basic_evt1");
        rd_expect(3'd2, 0, 0, "basic_evt0");
        rd_expect(3'd5, 0, 0, "basic_evt3");
        rd_expect(3'd6, 0, 0, "basic_oob");

        // Halt in cycle 7 with retire and evt[0]; then 20 frozen cycles.
        do_clr();
        en = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            retire = (i == 7) ? 1'b1 : 1'($urandom_range(1, 0));
            evt    = (i == 7) ? 4'b0001 : 4'($urandom_range(15, 0));
            hlt    = (i == 7);
            sel    = 3'($urandom_range(7, 0));
            cyc("halt");
        end
        chk("halt_frozen", 64'(frz_w), 64'd1);
        hlt = 1'b0;
        for (int i = 0; i < 20; i++) begin
            retire = 1'($urandom_range(1, 0));
            evt    = 4'($urandom_range(15, 0));
            hlt    = (i == 5);
            sel    = 3'($urandom_range(7, 0));
            cyc("frozen");
        end
        hlt = 1'b0; en = 1'b0;
        rd_expect(3'd0, 7, 7, "halt_cyc");

        // Watchdog: free run, u_w stops at 100, u_s saturates at 15.
        do_clr();
        en = 1'b1;
        for (int i = 0; i < 110; i++) begin
            retire = 1'($urandom_range(1, 0));
            sel    = 3'($urandom_range(7, 0));
            cyc("wdog");
        end
        chk("wdog_timeout", 64'(to_w), 64'd1);
        chk("wdog_frozen", 64'(frz_w), 64'd1);
        chk("wdog_off_s", 64'(to_s), 64'd0);
        chk("sat_cyc_ovf_s", 64'(ovf_s[0]), 64'd1);
        en = 1'b0; retire = 1'b0;
        rd_expect(3'd0, 100, 15, "wdog_cyc");
        do_clr();
        chk("wdog_clr_to", 64'(to_w), 64'd0);
        en = 1'b1;
        for (int i = 0; i < 3; i++) cyc("resume");
        en = 1'b0;
        rd_expect(3'd0, 3, 3, "resume_cyc");

        // Saturation: evt[2] held for 20 cycles.
        do_clr();
        en = 1'b1; evt = 4'b0100;
        for (int i = 1; i <= 20; i++) begin
            sel = 3'($urandom_range(7, 0));
            cyc("sat");
            if (i == 15) chk("sat_ovf_pre", 64'(ovf_s[4]), 64'd0);
            if (i == 16) chk("sat_ovf_set", 64'(ovf_s[4]), 64'd1);
        end
        en = 1'b0; evt = 4'd0;
        rd_expect(3'd4, 20, 15, "sat_evt2");
        chk("sat_ovf_sticky", 64'(ovf_s[4]), 64'd1);
        do_clr();
        chk("sat_ovf_clr", 64'(ovf_s[4]), 64'd0);

        // Snapshot at cycle 50, run to 80.
        en = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            snap = (i == 50);
            sel  = 3'($urandom_range(7, 0));
            cyc("snap");
        end
        snap = 1'b0; en = 1'b0;
        shadow = 1'b1;
        rd_expect(3'd0, SNAP_EN ? 50 : 80, 15, "snap_shadow");
        shadow = 1'b0;
        rd_expect(3'd0, 80, 15, "snap_live");

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            en     = ($urandom_range(7, 0) != 0);
            clr    = ($urandom_range(39, 0) == 0);
            hlt    = ($urandom_range(59, 0) == 0);
            retire = 1'($urandom_range(1, 0));
            evt    = 4'($urandom_range(15, 0));
            snap   = ($urandom_range(15, 0) == 0);
            shadow = 1'($urandom_range(1, 0));
            sel    = 3'($urandom_range(7, 0));
            cyc("rand");
        end

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        chk("async_rd_zero", 64'(bus_w.rd_data), 64'd0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            en     = 1'b1;
            clr    = 1'b0;
            hlt    = 1'b0;
            retire = 1'($urandom_range(1, 0));
            evt    = 4'($urandom_range(15, 0));
            snap   = 1'($urandom_range(1, 0));
            shadow = 1'($urandom_range(1, 0));
            sel    = 3'($urandom_range(7, 0));
            cyc("post_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
